// File: rtl/id_counter_ctrl.sv
// Sequencer/arbiter for the shared 8-bit ID counter: clears it after reset, services
// base-ID loads, and hands out unique IDs to requesters in round-robin order.
module id_counter_ctrl #(
    parameter int unsigned  NUM_REQ    = 4,
    parameter bit           ALLOW_WRAP = 1'b0,
    localparam int unsigned ID_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id_out,
    output logic               id_valid,
    input  logic               cfg_load,
    input  logic [ID_W-1:0]    cfg_data,
    output logic               cfg_done,
    output logic               exhausted,
    output logic               busy,
    output logic               cnt_rst,
    output logic               cnt_enable,
    output logic               cnt_load,
    output logic [ID_W-1:0]    cnt_load_data,
    output logic               cnt_oe,
    input  logic [ID_W-1:0]    cnt_q
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_DRIVE = 3'd3,
        S_ISSUE = 3'd4
    } state_t;

    state_t             r_state, w_next;
    logic [PTR_W-1:0]   r_rr, r_win, w_rr_d, w_win_d, w_pick, w_rr_inc;
    logic               w_found;
    logic [ID_W-1:0]    r_id, w_id_d;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_d;
    logic               r_id_valid, w_id_valid_d;
    logic               r_cfg_done, w_cfg_done_d;
    logic               r_exhausted, w_exhausted_d;
    logic               r_busy, w_busy_d;
    logic               r_cnt_enable, w_cnt_enable_d;
    logic               r_cnt_load, w_cnt_load_d;
    logic [ID_W-1:0]    r_cnt_load_data, w_cnt_load_data_d;

    // Round-robin pick: first set request at or after the pointer, ascending mod NUM_REQ
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[PTR_W'((32'(r_rr) + k) % NUM_REQ)]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'((32'(r_rr) + k) % NUM_REQ);
            end
        end
    end

    assign w_rr_inc = (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  w_next = S_IDLE;
            S_IDLE: begin
                if (cfg_load)                    w_next = S_LOAD;
                else if (w_found && !r_exhausted) w_next = S_DRIVE;
            end
            S_LOAD:  w_next = S_IDLE;
            S_DRIVE: w_next = S_ISSUE;
            S_ISSUE: w_next = S_IDLE;
            default: w_next = S_INIT;
        endcase
    end

    // Next values of the registered outputs; grant decision uses req sampled while driving
    always_comb begin
        w_gnt_d           = '0;
        w_id_valid_d      = 1'b0;
        w_cfg_done_d      = 1'b0;
        w_cnt_enable_d    = 1'b0;
        w_cnt_load_d      = 1'b0;
        w_cnt_load_data_d = '0;
        w_exhausted_d     = r_exhausted;
        w_rr_d            = r_rr;
        w_win_d           = r_win;
        w_id_d            = r_id;
        w_busy_d          = (w_next != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_next == S_LOAD) begin
                    w_cnt_load_d      = 1'b1;
                    w_cnt_load_data_d = cfg_data;
                    w_cfg_done_d      = 1'b1;
                    w_exhausted_d     = 1'b0;
                end else if (w_next == S_DRIVE) begin
                    w_win_d = w_pick;
                end
            end
            S_DRIVE: begin
                w_id_d = cnt_q;
                if (req[r_win]) begin
                    w_gnt_d        = NUM_REQ'(1) << r_win;
                    w_id_valid_d   = 1'b1;
                    w_cnt_enable_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (r_id_valid) begin
                    w_rr_d = w_rr_inc;
                    if (!ALLOW_WRAP && r_id == ID_W'(8'hFF)) w_exhausted_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt           <= '0;
            r_id_valid      <= 1'b0;
            r_cfg_done      <= 1'b0;
            r_cnt_enable    <= 1'b0;
            r_cnt_load      <= 1'b0;
            r_cnt_load_data <= '0;
            r_exhausted     <= 1'b0;
            r_busy          <= 1'b1;
            r_rr            <= '0;
            r_win           <= '0;
            r_id            <= '0;
        end else begin
            r_gnt           <= w_gnt_d;
            r_id_valid      <= w_id_valid_d;
            r_cfg_done      <= w_cfg_done_d;
            r_cnt_enable    <= w_cnt_enable_d;
            r_cnt_load      <= w_cnt_load_d;
            r_cnt_load_data <= w_cnt_load_data_d;
            r_exhausted     <= w_exhausted_d;
            r_busy          <= w_busy_d;
            r_rr            <= w_rr_d;
            r_win           <= w_win_d;
            r_id            <= w_id_d;
        end
    end

    assign cnt_rst       = (r_state == S_INIT);
    assign cnt_oe        = (r_state == S_DRIVE);
    assign gnt           = r_gnt;
    assign id_out        = r_id;
    assign id_valid      = r_id_valid;
    assign cfg_done      = r_cfg_done;
    assign exhausted     = r_exhausted;
    assign busy          = r_busy;
    assign cnt_enable    = r_cnt_enable;
    assign cnt_load      = r_cnt_load;
    assign cnt_load_data = r_cnt_load_data;

endmodule

// File: tb/tb_id_counter_ctrl.sv
// Bench for id_counter_ctrl: cycle-by-cycle vector table against a counter model,
// plus wrap (ALLOW_WRAP=1 instance), reset and mid-transaction reset sequences.
module tb_id_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // Main instance (ALLOW_WRAP=0)
    logic [3:0] req, gnt;
    logic [7:0] id_out, cfg_data, cnt_load_data;
    logic       id_valid, cfg_load, cfg_done, exhausted, busy;
    logic       cnt_rst, cnt_enable, cnt_load, cnt_oe;
    wire  [7:0] cnt_q;
    logic [7:0] cnt_m = 8'h55;

    // Wrap instance (ALLOW_WRAP=1)
    logic [3:0] req_w, gnt_w;
    logic [7:0] id_out_w, cfg_data_w, cnt_load_data_w;
    logic       id_valid_w, cfg_load_w, cfg_done_w, exhausted_w, busy_w;
    logic       cnt_rst_w, cnt_enable_w, cnt_load_w, cnt_oe_w;
    wire  [7:0] cnt_q_w;
    logic [7:0] cnt_mw = 8'h55;

    int checks   = 0;
    int failures = 0;

    id_counter_ctrl #(.NUM_REQ(4), .ALLOW_WRAP(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .id_out(id_out),
        .id_valid(id_valid), .cfg_load(cfg_load), .cfg_data(cfg_data),
        .cfg_done(cfg_done), .exhausted(exhausted), .busy(busy),
        .cnt_rst(cnt_rst), .cnt_enable(cnt_enable), .cnt_load(cnt_load),
        .cnt_load_data(cnt_load_data), .cnt_oe(cnt_oe), .cnt_q(cnt_q)
    );

    id_counter_ctrl #(.NUM_REQ(4), .ALLOW_WRAP(1'b1)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .req(req_w), .gnt(gnt_w), .id_out(id_out_w),
        .id_valid(id_valid_w), .cfg_load(cfg_load_w), .cfg_data(cfg_data_w),
        .cfg_done(cfg_done_w), .exhausted(exhausted_w), .busy(busy_w),
        .cnt_rst(cnt_rst_w), .cnt_enable(cnt_enable_w), .cnt_load(cnt_load_w),
        .cnt_load_data(cnt_load_data_w), .cnt_oe(cnt_oe_w), .cnt_q(cnt_q_w)
    );

    // Behavioural model of the shared 8-bit counter with tri-state q
    always @(posedge clk) begin
        if (cnt_rst)         cnt_m <= 8'h00;
        else if (cnt_load)   cnt_m <= cnt_load_data;
        else if (cnt_enable) cnt_m <= cnt_m + 8'h01;
        if (cnt_rst_w)         cnt_mw <= 8'h00;
        else if (cnt_load_w)   cnt_mw <= cnt_load_data_w;
        else if (cnt_enable_w) cnt_mw <= cnt_mw + 8'h01;
    end
    assign cnt_q   = cnt_oe   ? cnt_m  : 8'hzz;
    assign cnt_q_w = cnt_oe_w ? cnt_mw : 8'hzz;

    // Structural rules that must hold on every cycle
    always @(negedge clk) begin
        checks++;
        if ((cnt_load && cnt_enable) || !$onehot0(gnt) || (id_valid != (|gnt)) ||
            (cnt_load_w && cnt_enable_w) || !$onehot0(gnt_w) || (id_valid_w != (|gnt_w))) begin
            failures++;
            $display("FAIL invariant t=%0t gnt=%b id_valid=%b load=%b en=%b gnt_w=%b id_valid_w=%b",
                     $time, gnt, id_valid, cnt_load, cnt_enable, gnt_w, id_valid_w);
        end
    end

    typedef struct {
        logic [3:0] req;
        logic       cfg;
        logic [7:0] data;
        logic [3:0] gnt;
        logic       idv;
        logic [7:0] id;
        logic       oe, en, ld;
        logic [7:0] ldd;
        logic       done, busy, exh;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] rq, input logic cf, input logic [7:0] cd,
                       input logic [3:0] g, input logic iv, input logic [7:0] id,
                       input logic oe, input logic en, input logic ld, input logic [7:0] ldd,
                       input logic dn, input logic bz, input logic ex, input logic [7:0] cn);
        vec_t v;
        v.req = rq; v.cfg = cf; v.data = cd; v.gnt = g; v.idv = iv; v.id = id;
        v.oe = oe; v.en = en; v.ld = ld; v.ldd = ldd; v.done = dn; v.busy = bz;
        v.exh = ex; v.cnt = cn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] out_vec();
        return {gnt, id_valid, id_out, cnt_oe, cnt_enable, cnt_load, cnt_load_data,
                cfg_done, busy, exhausted, cnt_rst};
    endfunction

    localparam logic [27:0] RST_VEC = {4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00,
                                       1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [35:0] act, exp;
        logic [7:0]  got[3];
        int          n;

        rst_n = 1'b0; req = '0; cfg_load = 1'b0; cfg_data = '0;
        req_w = '0; cfg_load_w = 1'b0; cfg_data_w = '0;

        // Five grants with all four requesters held
        for (int g = 0; g < 5; g++) begin
            add(4'hF,0,8'h00, 4'h0,0,8'h00,               1,0,0,8'h00, 0,1,0, 8'(g));
            add(4'hF,0,8'h00, 4'(1 << (g % 4)),1,8'(g),   0,1,0,8'h00, 0,1,0, 8'(g));
            add(4'hF,0,8'h00, 4'h0,0,8'h00,               0,0,0,8'h00, 0,0,0, 8'(g + 1));
        end
        // Load A5, then requester 2
        add(4'h0,1,8'hA5, 4'h0,0,8'h00, 0,0,1,8'hA5, 1,1,0, 8'h05);
        add(4'h4,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'hA5);
        add(4'h4,0,8'h00, 4'h0,0,8'h00, 1,0,0,8'h00, 0,1,0, 8'hA5);
        add(4'h4,0,8'h00, 4'h4,1,8'hA5, 0,1,0,8'h00, 0,1,0, 8'hA5);
        add(4'h0,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'hA6);
        // cfg_load and req[1] on the same edge: load wins
        add(4'h2,1,8'h3C, 4'h0,0,8'h00, 0,0,1,8'h3C, 1,1,0, 8'hA6);
        add(4'h2,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'h3C);
        add(4'h2,0,8'h00, 4'h0,0,8'h00, 1,0,0,8'h00, 0,1,0, 8'h3C);
        add(4'h2,0,8'h00, 4'h2,1,8'h3C, 0,1,0,8'h00, 0,1,0, 8'h3C);
        add(4'h0,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'h3D);
        // Exhaustion after FF, requests ignored, reload clears it
        add(4'h0,1,8'hFE, 4'h0,0,8'h00, 0,0,1,8'hFE, 1,1,0, 8'h3D);
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'hFE);
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 1,0,0,8'h00, 0,1,0, 8'hFE);
        add(4'h1,0,8'h00, 4'h1,1,8'hFE, 0,1,0,8'h00, 0,1,0, 8'hFE);
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'hFF);
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 1,0,0,8'h00, 0,1,0, 8'hFF);
        add(4'h1,0,8'h00, 4'h1,1,8'hFF, 0,1,0,8'h00, 0,1,0, 8'hFF);
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,1, 8'h00);
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,1, 8'h00);
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,1, 8'h00);
        add(4'h1,1,8'h10, 4'h0,0,8'h00, 0,0,1,8'h10, 1,1,0, 8'h00);
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'h10);
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 1,0,0,8'h00, 0,1,0, 8'h10);
        add(4'h1,0,8'h00, 4'h1,1,8'h10, 0,1,0,8'h00, 0,1,0, 8'h10);
        add(4'h0,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'h11);
        // req[3] dropped during DRIVE: nothing consumed, pointer unchanged (3 still wins next)
        add(4'h8,0,8'h00, 4'h0,0,8'h00, 1,0,0,8'h00, 0,1,0, 8'h11);
        add(4'h0,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,1,0, 8'h11);
        add(4'h0,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'h11);
        add(4'h9,0,8'h00, 4'h0,0,8'h00, 1,0,0,8'h00, 0,1,0, 8'h11);
        add(4'h9,0,8'h00, 4'h8,1,8'h11, 0,1,0,8'h00, 0,1,0, 8'h11);
        add(4'h0,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'h12);
        // cfg_load raised during DRIVE is held pending until IDLE
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 1,0,0,8'h00, 0,1,0, 8'h12);
        add(4'h1,1,8'h77, 4'h1,1,8'h12, 0,1,0,8'h00, 0,1,0, 8'h12);
        add(4'h0,1,8'h77, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'h13);
        add(4'h0,1,8'h77, 4'h0,0,8'h00, 0,0,1,8'h77, 1,1,0, 8'h13);
        add(4'h0,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'h77);
        // cfg_load pulse that drops before IDLE is ignored
        add(4'h1,0,8'h00, 4'h0,0,8'h00, 1,0,0,8'h00, 0,1,0, 8'h77);
        add(4'h1,1,8'h99, 4'h1,1,8'h77, 0,1,0,8'h00, 0,1,0, 8'h77);
        add(4'h0,0,8'h00, 4'h0,0,8'h00, 0,0,0,8'h00, 0,0,0, 8'h78);

        // Reset state, then INIT lasts exactly one cycle and clears the counter
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(out_vec()), 64'(RST_VEC));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_cnt_rst_high", 64'(cnt_rst), 64'd1);
        @(posedge clk);
        #1;
        chk("init_done", 64'({cnt_rst, busy, cnt_m, cnt_rst_w, cnt_mw}),
            64'({1'b0, 1'b0, 8'h00, 1'b0, 8'h00}));

        for (int i = 0; i < vecs.size(); i++) begin
            req      = vecs[i].req;
            cfg_load = vecs[i].cfg;
            cfg_data = vecs[i].data;
            @(posedge clk);
            #1;
            act = {gnt, id_valid, (vecs[i].idv ? id_out : 8'h00), cnt_oe, cnt_enable,
                   cnt_load, cnt_load_data, cfg_done, busy, exhausted, cnt_rst, cnt_m};
            exp = {vecs[i].gnt, vecs[i].idv, vecs[i].id, vecs[i].oe, vecs[i].en,
                   vecs[i].ld, vecs[i].ldd, vecs[i].done, vecs[i].busy, vecs[i].exh,
                   1'b0, vecs[i].cnt};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL vec[%0d] actual=%h required=%h", i, act, exp);
            end
        end
        req = '0; cfg_load = 1'b0; cfg_data = '0;

        // ALLOW_WRAP=1: FE, FF, then 00 with exhausted staying low
        cfg_load_w = 1'b1; cfg_data_w = 8'hFE;
        @(posedge clk);
        #1;
        cfg_load_w = 1'b0; req_w = 4'h1;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(posedge clk);
            #1;
            if (id_valid_w) begin
                got[n] = id_out_w;
                n++;
            end
        end
        req_w = '0;
        chk("wrap_grant_count", 64'(n), 64'd3);
        if (n == 3) begin
            chk("wrap_id0", 64'(got[0]), 64'hFE);
            chk("wrap_id1", 64'(got[1]), 64'hFF);
            chk("wrap_id2", 64'(got[2]), 64'h00);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_not_exhausted", 64'({exhausted_w, busy_w}), 64'd0);

        // Reset asserted while the bus is being driven
        req = 4'h1;
        @(posedge clk);
        #1;
        chk("pre_reset_drive", 64'({cnt_oe, busy}), 64'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_drive", 64'(out_vec()), 64'(RST_VEC));
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reinit_cnt_rst_high", 64'(cnt_rst), 64'd1);
        @(posedge clk);
        #1;
        chk("reinit_done", 64'({cnt_rst, busy, cnt_oe, cnt_m}), 64'({1'b0, 1'b0, 1'b0, 8'h00}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
